// File: rtl/calc_driver.sv
// calc_driver: queues calculator commands in a small FIFO and sequences each one
// through setup, a single-cycle execute strobe, a settle window and result capture,
// presenting the captured result on a valid/ready response port.

package calc_driver_pkg;

    // One queued calculator command.
    typedef struct packed {
        logic [3:0] op;
        logic [7:0] operand;
    } cmd_t;

    // Opcodes the calculator does not implement; rejected without a strobe.
    localparam logic [3:0] OP_RSVD_B = 4'hB;
    localparam logic [3:0] OP_RSVD_C = 4'hC;

endpackage : calc_driver_pkg

module calc_driver
    import calc_driver_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [7:0] cmd_operand,

    output logic [7:0] calc_operand,
    output logic [3:0] calc_op,
    output logic       calc_go,
    input  logic [7:0] calc_result,
    input  logic [2:0] calc_flags,

    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_result,
    output logic [2:0] rsp_flags,
    output logic [3:0] rsp_op,
    output logic       rsp_err,

    output logic       busy
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    // Settle counter holds SETTLE_CYCLES-1 down to zero.
    localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);
    localparam logic [SET_W-1:0] SETTLE_INI = SET_W'(SETTLE_CYCLES - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_STROBE  = 3'd2;
    localparam logic [2:0] ST_SETTLE  = 3'd3;
    localparam logic [2:0] ST_CAPTURE = 3'd4;
    localparam logic [2:0] ST_RESP    = 3'd5;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    cmd_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    cmd_t             cmd_in;
    cmd_t             head;
    logic             push;
    logic             pop;

    logic [2:0]       state;
    logic [2:0]       state_d;

    assign cmd_in    = '{op: cmd_op, operand: cmd_operand};
    assign head      = fifo_mem[rd_ptr];
    assign cmd_ready = (count != FULL_CNT);
    assign push      = cmd_valid && cmd_ready;
    // The FSM only takes a new command from IDLE, so one is in flight at most.
    assign pop       = (state == ST_IDLE) && (count != '0);
    assign busy      = (state != ST_IDLE) || (count != '0);

    // FIFO storage: written on push, no reset needed since count guards reads.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= cmd_in;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    cmd_t             wrk;
    cmd_t             wrk_d;
    logic [SET_W-1:0] settle_cnt;
    logic [SET_W-1:0] settle_d;

    logic             calc_go_d;
    logic [3:0]       calc_op_d;
    logic [7:0]       calc_operand_d;
    logic             rsp_valid_d;
    logic [7:0]       rsp_result_d;
    logic [2:0]       rsp_flags_d;
    logic [3:0]       rsp_op_d;
    logic             rsp_err_d;

    // State register plus registered calculator and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            wrk          <= '0;
            settle_cnt   <= '0;
            calc_go      <= 1'b0;
            calc_op      <= '0;
            calc_operand <= '0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_flags    <= '0;
            rsp_op       <= '0;
            rsp_err      <= 1'b0;
        end else begin
            state        <= state_d;
            wrk          <= wrk_d;
            settle_cnt   <= settle_d;
            calc_go      <= calc_go_d;
            calc_op      <= calc_op_d;
            calc_operand <= calc_operand_d;
            rsp_valid    <= rsp_valid_d;
            rsp_result   <= rsp_result_d;
            rsp_flags    <= rsp_flags_d;
            rsp_op       <= rsp_op_d;
            rsp_err      <= rsp_err_d;
        end
    end

    // Next-state and next-output logic; outputs hold unless a state updates them.
    always_comb begin
        state_d        = state;
        wrk_d          = wrk;
        settle_d       = settle_cnt;
        calc_go_d      = 1'b0;
        calc_op_d      = calc_op;
        calc_operand_d = calc_operand;
        rsp_valid_d    = rsp_valid;
        rsp_result_d   = rsp_result;
        rsp_flags_d    = rsp_flags;
        rsp_op_d       = rsp_op;
        rsp_err_d      = rsp_err;

        unique case (state)
            ST_IDLE: begin
                if (count != '0) begin
                    // Calculator inputs are loaded with the pop so they are
                    // already stable for the whole SETUP cycle.
                    wrk_d          = head;
                    calc_op_d      = head.op;
                    calc_operand_d = head.operand;
                    state_d        = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if ((wrk.op == OP_RSVD_B) || (wrk.op == OP_RSVD_C)) begin
                    rsp_valid_d  = 1'b1;
                    rsp_err_d    = 1'b1;
                    rsp_result_d = '0;
                    rsp_flags_d  = '0;
                    rsp_op_d     = wrk.op;
                    state_d      = ST_RESP;
                end else begin
                    // Registered strobe is high for exactly the STROBE cycle.
                    calc_go_d = 1'b1;
                    state_d   = ST_STROBE;
                end
            end

            ST_STROBE: begin
                settle_d = SETTLE_INI;
                state_d  = ST_SETTLE;
            end

            ST_SETTLE: begin
                if (settle_cnt == '0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    settle_d = settle_cnt - SET_W'(1);
                end
            end

            ST_CAPTURE: begin
                rsp_valid_d  = 1'b1;
                rsp_err_d    = 1'b0;
                rsp_result_d = calc_result;
                rsp_flags_d  = calc_flags;
                rsp_op_d     = wrk.op;
                state_d      = ST_RESP;
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule : calc_driver

// File: tb/tb_calc_driver.sv
// Self-checking bench for calc_driver: a calculator device model, a reference
// model predicting each response at command acceptance, and a decoupled monitor.

module tb_calc_driver;

    localparam int DEPTH  = 4;
    localparam int SETTLE = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_operand;
    logic [7:0] calc_operand;
    logic [3:0] calc_op;
    logic       calc_go;
    logic [7:0] calc_result;
    logic [2:0] calc_flags;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_result;
    logic [2:0] rsp_flags;
    logic [3:0] rsp_op;
    logic       rsp_err;
    logic       busy;

    typedef struct packed {
        logic [3:0] op;
        logic       err;
        logic [7:0] result;
        logic [2:0] flags;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_err    = 0;
    int         cyc      = 0;
    int         acc_cyc  = 0;
    int         rdy_mode = 0;
    logic [7:0] ref_acc;
    int         go_pulses = 0;
    int         high_run  = 0;
    int         low_run   = 0;
    bit         seen_go   = 1'b0;

    calc_driver #(
        .FIFO_DEPTH    (DEPTH),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_operand  (cmd_operand),
        .calc_operand (calc_operand),
        .calc_op      (calc_op),
        .calc_go      (calc_go),
        .calc_result  (calc_result),
        .calc_flags   (calc_flags),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_flags    (rsp_flags),
        .rsp_op       (rsp_op),
        .rsp_err      (rsp_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Calculator arithmetic: returns {overflow, neg, zero, result}.
    function automatic logic [10:0] alu(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] r;
        logic       ov;
        ov = 1'b0;
        case (op)
            4'h0: begin r = a + b; ov = (a[7] == b[7]) && (r[7] != a[7]); end
            4'h1: begin r = a - b; ov = (a[7] != b[7]) && (r[7] != a[7]); end
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = a ^ b;
            default: r = b;
        endcase
        return {ov, r[7], (r == 8'h00), r};
    endfunction

    // Calculator device: accumulator updated on each execute strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            calc_result <= 8'h00;
            calc_flags  <= 3'b000;
        end else if (calc_go) begin
            {calc_flags, calc_result} <= alu(calc_op, calc_result, calc_operand);
        end
    end

    task automatic check(input bit ok, input string name, input logic [31:0] act,
                         input logic [31:0] expv);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic check_eq(input string name, input logic [31:0] act,
                            input logic [31:0] expv);
        check(act == expv, name, act, expv);
    endtask

    // Reference: responses come back in order; reserved opcodes never touch the accumulator.
    task automatic model_push(input logic [3:0] op, input logic [7:0] opd);
        exp_t       e;
        logic [10:0] v;
        e.op = op;
        if (op == 4'hB || op == 4'hC) begin
            e.err    = 1'b1;
            e.result = 8'h00;
            e.flags  = 3'b000;
        end else begin
            v        = alu(op, ref_acc, opd);
            ref_acc  = v[7:0];
            e.err    = 1'b0;
            e.result = v[7:0];
            e.flags  = v[10:8];
        end
        exp_q.push_back(e);
    endtask

    // Offer one command for up to budget cycles; starts and ends just after a rising edge.
    task automatic offer(input logic [3:0] op, input logic [7:0] opd, input int budget,
                         output bit acc);
        acc         = 1'b0;
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_operand = opd;
        for (int i = 0; i < budget && !acc; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                acc     = 1'b1;
                acc_cyc = cyc + 1;
                model_push(op, opd);
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic offer_must(input logic [3:0] op, input logic [7:0] opd);
        bit a;
        offer(op, opd, 60, a);
        check(a, "cmd_accept", 32'(a), 32'd1);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !busy) break;
            @(posedge clk);
            #1;
        end
        check(exp_q.size() == 0 && !busy, "drain", 32'(exp_q.size()), 32'd0);
    endtask

    // rsp_ready driver, changing well after the edge so the monitor sees it stable.
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       rsp_ready = 1'b0;
            1:       rsp_ready = 1'b1;
            default: rsp_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: every response handshake is matched against the oldest prediction.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_rsp", 32'({rsp_op, rsp_result}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("rsp_op",     32'(rsp_op),     32'(e.op));
                check_eq("rsp_err",    32'(rsp_err),    32'(e.err));
                check_eq("rsp_result", 32'(rsp_result), 32'(e.result));
                check_eq("rsp_flags",  32'(rsp_flags),  32'(e.flags));
            end
        end
    end

    // Strobe checker: one-cycle pulses with at least four low cycles between them.
    always @(negedge clk) begin
        if (!rst_n) begin
            high_run = 0;
            low_run  = 0;
        end else if (calc_go) begin
            if (high_run == 0) begin
                go_pulses++;
                if (seen_go) check(low_run >= 4, "go_gap", 32'(low_run), 32'd4);
                seen_go = 1'b1;
                low_run = 0;
            end
            high_run++;
        end else begin
            if (high_run > 0) check_eq("go_width", 32'(high_run), 32'd1);
            high_run = 0;
            low_run++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         start;
        int         accepted;
        bit         a;
        int         gap;
        logic [3:0] rop;
        logic [7:0] ropd;

        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = 4'h0;
        cmd_operand = 8'h00;
        ref_acc     = 8'h00;
        repeat (3) @(posedge clk);
        #1;

        check_eq("rst_calc_go",      32'(calc_go),      32'd0);
        check_eq("rst_calc_op",      32'(calc_op),      32'd0);
        check_eq("rst_calc_operand", 32'(calc_operand), 32'd0);
        check_eq("rst_rsp_valid",    32'(rsp_valid),    32'd0);
        check_eq("rst_rsp_result",   32'(rsp_result),   32'd0);
        check_eq("rst_rsp_flags",    32'(rsp_flags),    32'd0);
        check_eq("rst_rsp_op",       32'(rsp_op),       32'd0);
        check_eq("rst_rsp_err",      32'(rsp_err),      32'd0);
        check_eq("rst_cmd_ready",    32'(cmd_ready),    32'd1);
        check_eq("rst_busy",         32'(busy),         32'd0);

        rst_n = 1'b1;
        wait_cycles(2);

        // Add 5 to a zero accumulator; response appears pop+4 (accept+5) cycles later.
        rdy_mode = 0;
        start    = go_pulses;
        offer_must(4'h0, 8'h05);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        check_eq("latency", 32'(cyc - acc_cyc), 32'(1 + 3 + SETTLE));
        check_eq("go_pulses_add", 32'(go_pulses - start), 32'd1);
        @(posedge clk);
        #1;
        rdy_mode = 1;
        wait_drain(30);

        // Subtract back to zero: zero flag.
        offer_must(4'h1, 8'h05);
        wait_drain(30);

        // Reserved opcode: error response, no strobe.
        start = go_pulses;
        offer_must(4'hB, 8'h77);
        wait_drain(30);
        check_eq("err_no_go", 32'(go_pulses - start), 32'd0);

        // Two back-to-back executes with the response always consumed.
        offer_must(4'h2, 8'hF0);
        offer_must(4'h0, 8'h11);
        wait_drain(40);

        // Backpressure: one in RESP plus a full FIFO, sixth refused.
        rdy_mode = 0;
        wait_cycles(2);
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            offer(4'(i % 5), 8'(8'h10 + i), 3, a);
            if (a) accepted++;
        end
        check_eq("bp_accepted",  32'(accepted),  32'd5);
        check_eq("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        check_eq("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        rdy_mode = 1;
        wait_drain(100);

        // Reset while the strobe is high: everything in flight is discarded.
        offer_must(4'h0, 8'h21);
        offer_must(4'h1, 8'h02);
        offer_must(4'h3, 8'h40);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (calc_go) break;
        end
        check_eq("rst_saw_go", 32'(calc_go), 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        ref_acc = 8'h00;
        #1;
        check_eq("rst_async_go",  32'(calc_go), 32'd0);
        check_eq("rst_async_op",  32'(calc_op), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_eq("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("post_rst_busy",      32'(busy),      32'd0);
        wait_cycles(10);
        check_eq("post_rst_quiet", 32'({busy, rsp_valid}), 32'd0);
        offer_must(4'h0, 8'h33);
        wait_drain(30);

        // Randomized traffic with random response backpressure.
        rdy_mode = 2;
        for (int i = 0; i < 60; i++) begin
            gap = int'($urandom_range(0, 2));
            wait_cycles(gap);
            rop  = 4'($urandom_range(0, 15));
            ropd = 8'($urandom);
            offer_must(rop, ropd);
        end
        rdy_mode = 1;
        wait_drain(300);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_calc_driver
